// File: rtl/stoch_mul_if.sv
// Request/result bundle for the stochastic multiplier core.
// The master issues start with operands; the slave returns busy, done and the window count.
interface stoch_mul_if #(
  parameter int PW       = 4,
  parameter int WIN_LOG2 = 3
);
  logic                start;
  logic                mode;
  logic [PW-1:0]       prob_a;
  logic [PW-1:0]       prob_b;
  logic                busy;
  logic                done;
  logic [WIN_LOG2:0]   count;
  logic                saturated;
  logic                sn_out;

  modport master (
    output start, mode, prob_a, prob_b,
    input  busy, done, count, saturated, sn_out
  );

  modport slave (
    input  start, mode, prob_a, prob_b,
    output busy, done, count, saturated, sn_out
  );
endinterface

// File: rtl/stoch_mul_core.sv
// Stochastic-computing multiplier: two free-running LFSRs turn probability codes into
// bitstreams, which are ANDed (unipolar) or XNORed (bipolar) and counted over a 2^WIN_LOG2 window.
module stoch_mul_core #(
  parameter int PW       = 4,
  parameter int LFSR_W   = 31,
  parameter int TAP_A    = 27,
  parameter int TAP_B    = 24,
  parameter int SEED_A   = 1,
  parameter int SEED_B   = 2,
  parameter int WIN_LOG2 = 3
) (
  input logic        clk,
  input logic        rst_n,
  stoch_mul_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [LFSR_W-1:0]   SEED_A_V = LFSR_W'(SEED_A);
  localparam logic [LFSR_W-1:0]   SEED_B_V = LFSR_W'(SEED_B);
  localparam logic [WIN_LOG2:0]   N_VAL    = {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [WIN_LOG2-1:0] CNT_ONE  = WIN_LOG2'(1);
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  state_t              state;
  logic [LFSR_W-1:0]   lfsr_a;
  logic [LFSR_W-1:0]   lfsr_b;
  logic [PW-1:0]       prob_a_q;
  logic [PW-1:0]       prob_b_q;
  logic                mode_q;
  logic [WIN_LOG2:0]   acc;
  logic [WIN_LOG2-1:0] bit_cnt;
  logic                busy_r;
  logic                done_r;
  logic [WIN_LOG2:0]   count_r;
  logic                sat_r;
  logic                sn_out_r;

  logic sn_a;
  logic sn_b;
  logic prod;

  // An all-zero register is the LFSR lock-up state, so it is escaped by reloading the seed.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q,
                                                  input logic              fb,
                                                  input logic [LFSR_W-1:0] seed);
    if (q == '0) return seed;
    return {q[LFSR_W-2:0], fb};
  endfunction

  always_comb begin
    sn_a = (lfsr_a[LFSR_W-1 -: PW] < prob_a_q);
    sn_b = (lfsr_b[LFSR_W-1 -: PW] < prob_b_q);
    prod = mode_q ? ~(sn_a ^ sn_b) : (sn_a & sn_b);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      lfsr_a   <= SEED_A_V;
      lfsr_b   <= SEED_B_V;
      prob_a_q <= '0;
      prob_b_q <= '0;
      mode_q   <= 1'b0;
      acc      <= '0;
      bit_cnt  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      count_r  <= '0;
      sat_r    <= 1'b0;
      sn_out_r <= 1'b0;
    end else begin
      lfsr_a   <= lfsr_next(lfsr_a, lfsr_a[LFSR_W-1] ^ lfsr_a[TAP_A], SEED_A_V);
      lfsr_b   <= lfsr_next(lfsr_b, lfsr_b[LFSR_W-1] ^ lfsr_b[TAP_B], SEED_B_V);
      done_r   <= 1'b0;
      sn_out_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            prob_a_q <= bus.prob_a;
            prob_b_q <= bus.prob_b;
            mode_q   <= bus.mode;
            acc      <= '0;
            bit_cnt  <= '0;
            busy_r   <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // acc is one bit wider than the counter so a full window of ones reaches N without wrapping.
          acc      <= acc + (WIN_LOG2+1)'(prod);
          bit_cnt  <= bit_cnt + CNT_ONE;
          sn_out_r <= prod;
          if (bit_cnt == CNT_LAST) state <= DONE;
        end
        DONE: begin
          count_r <= acc;
          sat_r   <= (acc == N_VAL);
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.count     = count_r;
  assign bus.saturated = sat_r;
  assign bus.sn_out    = sn_out_r;

endmodule

// File: tb/tb_stoch_mul_core.sv
// Bench for stoch_mul_core: constant-expectation vectors, multi-cycle sequences and random
// operations scored against an arithmetic model of the two LFSR bitstreams.
module tb_stoch_mul_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stoch_mul_if #(.PW(4), .WIN_LOG2(3)) b0 ();
  stoch_mul_if #(.PW(6), .WIN_LOG2(8)) b1 ();

  stoch_mul_core u0 (.clk(clk), .rst_n(rst), .bus(b0.slave));
  stoch_mul_core #(.PW(6), .WIN_LOG2(8)) u1 (.clk(clk), .rst_n(rst), .bus(b1.slave));

  int total = 0;
  int bad   = 0;

  localparam int unsigned MASK = 32'h7fff_ffff;

  // Reference LFSR state tracking the default instance, cycle for cycle.
  int unsigned ma;
  int unsigned mb;

  function automatic int unsigned lstep(int unsigned q, int tap, int unsigned seed);
    if (q == 0) return seed;
    return ((q << 1) & MASK) | (((q >> 30) ^ (q >> tap)) & 32'd1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ma <= 1;
      mb <= 2;
    end else begin
      ma <= lstep(ma, 27, 1);
      mb <= lstep(mb, 24, 2);
    end
  end

  // Window count for an operation whose LFSR values before the accepting edge were la/lb,
  // skipping 'skip' extra cycles first (used for back-to-back operations).
  function automatic int exp_count(int unsigned la, int unsigned lb, int skip, int pa, int pb, bit m);
    int unsigned a = la;
    int unsigned b = lb;
    int c = 0;
    bit sa, sb;
    for (int k = 0; k < skip; k++) begin
      a = lstep(a, 27, 1);
      b = lstep(b, 24, 2);
    end
    for (int j = 0; j < 8; j++) begin
      a = lstep(a, 27, 1);
      b = lstep(b, 24, 2);
      sa = ((a >> 27) & 15) < pa;
      sb = ((b >> 27) & 15) < pb;
      if (m ? (sa == sb) : (sa && sb)) c++;
    end
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One operation on the default instance; jitter scrambles inputs while the core is busy.
  task automatic run_op(input bit m, input int pa, input int pb, input bit use_model,
                        input int expc, input bit jitter);
    int e, lat;
    bit seen;
    @(negedge clk);
    b0.start  = 1'b1;
    b0.mode   = m;
    b0.prob_a = 4'(pa);
    b0.prob_b = 4'(pb);
    e = use_model ? exp_count(ma, mb, 0, pa, pb, m) : expc;
    @(negedge clk);
    b0.start = 1'b0;
    chk("busy_after_start", int'(b0.busy), 1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      if (jitter) begin
        b0.start  = 1'($urandom);
        b0.mode   = 1'($urandom);
        b0.prob_a = 4'($urandom);
        b0.prob_b = 4'($urandom);
      end
      @(negedge clk);
      lat++;
      if (b0.done) seen = 1'b1;
    end
    b0.start = 1'b0;
    chk("done_latency", lat, 9);
    chk("count", int'(b0.count), e);
    chk("saturated", int'(b0.saturated), (e == 8) ? 1 : 0);
    chk("busy_at_done", int'(b0.busy), 0);
    @(negedge clk);
    chk("done_pulse_width", int'(b0.done), 0);
  endtask

  typedef struct {
    bit mode;
    int pa;
    int pb;
    bit use_model;
    int expc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int m_cnt, ndone, lat;
    int e_held[3];
    bit seen;

    b0.start = 0; b0.mode = 0; b0.prob_a = 0; b0.prob_b = 0;
    b1.start = 0; b1.mode = 0; b1.prob_a = 0; b1.prob_b = 0;

    vecs[0] = '{0, 0, 15, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 8};
    vecs[2] = '{0, 15, 0, 0, 0};
    vecs[3] = '{0, 0, 0, 0, 0};
    vecs[4] = '{1, 15, 15, 1, 0};
    vecs[5] = '{0, 15, 15, 1, 0};
    vecs[6] = '{1, 8, 3, 1, 0};
    vecs[7] = '{0, 7, 9, 1, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(b0.busy), 0);
    chk("rst_done", int'(b0.done), 0);
    chk("rst_count", int'(b0.count), 0);
    chk("rst_sat", int'(b0.saturated), 0);
    chk("rst_sn_out", int'(b0.sn_out), 0);
    chk("rst_lfsr_a", int'(u0.lfsr_a), 1);
    chk("rst_lfsr_b", int'(u0.lfsr_b), 2);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].mode, vecs[i].pa, vecs[i].pb, vecs[i].use_model, vecs[i].expc, 1'b0);

    // Bipolar zero operands: product stream is all ones, visible on sn_out for exactly 8 cycles.
    @(negedge clk);
    b0.start = 1; b0.mode = 1; b0.prob_a = 0; b0.prob_b = 0;
    for (int m = 0; m < 10; m++) begin
      @(negedge clk);
      b0.start = 0;
      chk("sn_out_seq", int'(b0.sn_out), (m >= 1 && m <= 8) ? 1 : 0);
    end
    chk("seq_done", int'(b0.done), 1);
    chk("seq_count", int'(b0.count), 8);
    chk("seq_sat", int'(b0.saturated), 1);

    // Reset during the fourth RUN cycle aborts the operation.
    @(negedge clk);
    b0.start = 1; b0.mode = 1; b0.prob_a = 0; b0.prob_b = 0;
    @(negedge clk);
    b0.start = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(b0.busy), 0);
    chk("abort_done", int'(b0.done), 0);
    chk("abort_count", int'(b0.count), 0);
    chk("abort_sat", int'(b0.saturated), 0);
    chk("abort_lfsr_a", int'(u0.lfsr_a), 1);
    chk("abort_lfsr_b", int'(u0.lfsr_b), 2);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (b0.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op(1, 0, 0, 1'b0, 8, 1'b0);
    run_op(0, 11, 6, 1'b1, 0, 1'b0);

    // start held high: one result every 10 cycles, operands scrambled during RUN.
    @(negedge clk);
    b0.start = 1; b0.mode = 1; b0.prob_a = 9; b0.prob_b = 5;
    for (int k = 0; k < 3; k++) e_held[k] = exp_count(ma, mb, 10 * k, 9, 5, 1'b1);
    for (int m = 0; m < 30; m++) begin
      @(negedge clk);
      if ((m % 10) == 9) begin
        chk("held_done", int'(b0.done), 1);
        chk("held_count", int'(b0.count), e_held[m / 10]);
      end else begin
        chk("held_no_done", int'(b0.done), 0);
      end
      if ((m % 10) < 8) begin
        b0.mode   = 1'($urandom);
        b0.prob_a = 4'($urandom);
        b0.prob_b = 4'($urandom);
      end else begin
        b0.mode = 1; b0.prob_a = 9; b0.prob_b = 5;
      end
    end
    b0.start = 0;
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      m_cnt = $urandom_range(0, 3);
      repeat (m_cnt) @(negedge clk);
      run_op(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1, 0, 1'b1);
    end

    // Wide instance: 256-bit window of all ones.
    @(negedge clk);
    b1.start = 1; b1.mode = 1; b1.prob_a = 0; b1.prob_b = 0;
    @(negedge clk);
    b1.start = 0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 400) begin
      @(negedge clk);
      lat++;
      if (b1.done) seen = 1'b1;
    end
    chk("wide_latency", lat, 257);
    chk("wide_count", int'(b1.count), 256);
    chk("wide_sat", int'(b1.saturated), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stoch_mul_core.md
STOCH_MUL_CORE -- requirements
Module: stoch_mul_core

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PW, 4, probability input width in bits (2..8).
- LFSR_W, 31, width of each LFSR (>= PW+1).
- TAP_A, 27, second feedback tap of LFSR A; the first tap is always bit LFSR_W-1.
- TAP_B, 24, second feedback tap of LFSR B; the first tap is always bit LFSR_W-1.
- SEED_A, 1, nonzero reset value of LFSR A.
- SEED_B, 2, nonzero reset value of LFSR B; must differ from SEED_A.
- WIN_LOG2, 3, log2 of the accumulation window N = 2^WIN_LOG2 bits (1..12).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock; all state changes on its rising edge.
- rst_n, in, 1, reset; synchronous and active-high despite the name; 1 = reset.
- start, in, 1, request for one multiplication; sampled only in IDLE.
- mode, in, 1, 0 = unipolar (AND), 1 = bipolar (XNOR); captured on start.
- prob_a, in, PW, operand A probability code; captured on start.
- prob_b, in, PW, operand B probability code; captured on start.
- busy, out, 1, high while in RUN or DONE.
- done, out, 1, one-cycle pulse when a new result is valid.
- count, out, WIN_LOG2+1, number of 1 bits in the last completed window (0..N).
- saturated, out, 1, high when count == N.
- sn_out, out, 1, registered product bit of the current RUN cycle (debug).

Function
REQ-003 The LFSRs SHALL free-run every non-reset cycle: next[0] = q[LFSR_W-1] ^ q[TAP_x], and next[LFSR_W-1:1] = q[LFSR_W-2:0].
REQ-004 If an LFSR holds all zeros, it SHALL reload its seed on the next cycle instead of shifting.
REQ-005 Each cycle, sn_a SHALL be (lfsrA[LFSR_W-1 -: PW] < prob_a_q), unsigned; sn_b SHALL be computed the same way from lfsrB and prob_b_q.
REQ-006 The product bit SHALL be sn_a & sn_b when mode_q = 0, and ~(sn_a ^ sn_b) when mode_q = 1.
REQ-007 The FSM SHALL have the states IDLE, RUN and DONE.
- IDLE: start=1 captures prob_a, prob_b and mode into the _q registers, clears the accumulator and bit counter, and moves to RUN.
- RUN: lasts exactly N cycles. Each cycle, the accumulator adds the product bit and the bit counter increments. When the bit counter reaches N-1, the FSM moves to DONE.
- DONE: lasts one cycle. count is loaded from the final accumulator value (including the last bit), done=1, and the FSM returns to IDLE.
REQ-008 Latency from the start-accepted edge to done high SHALL be N+1 cycles; back-to-back operation SHALL allow a new start one cycle after done (throughput of one result per N+2 cycles).
REQ-009 start SHALL be ignored in RUN and DONE; captured operands SHALL remain stable through RUN regardless of input changes.
REQ-010 The accumulator SHALL be WIN_LOG2+1 bits wide and SHALL never wrap; an all-ones window SHALL yield count = N and saturated = 1.
REQ-011 count and saturated SHALL hold their values between done pulses and update only in DONE.
REQ-012 sn_out SHALL be the product bit registered during RUN, and 0 outside RUN.
REQ-013 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-014 On rst_n=1 at a clock edge, the module SHALL:
- set the state to IDLE;
- load SEED_A and SEED_B into the LFSRs;
- clear the accumulator, bit counter and _q registers;
- drive busy=0, done=0, count=0, saturated=0, sn_out=0.
REQ-015 Reset asserted mid-RUN SHALL abort the operation: no done pulse, count stays 0, and the next start after reset is accepted normally.
REQ-016 Reset SHALL override start in the same cycle.

Verification
REQ-017 Defaults, mode=0, prob_a=0, prob_b=15, start pulse -> done exactly 9 cycles after the accepting edge, count=0, saturated=0.
REQ-018 Defaults, mode=1, prob_a=0, prob_b=0 -> count=8, saturated=1, sn_out=1 for all 8 RUN cycles.
REQ-019 Random prob_a/prob_b/mode, 1000 operations, compared against a bit-accurate model of the LFSRs (seeded and free-running from reset) -> count matches every time, and busy/done timing matches REQ-008.
REQ-020 start held high continuously -> one result per 10 cycles; operand changes during RUN have no effect on count.
REQ-021 rst_n=1 for one cycle at RUN cycle 4 -> busy=0 next cycle, no done pulse, count=0; LFSRs equal SEED_A/SEED_B.
REQ-022 Parameter sweep with PW=6, WIN_LOG2=8, mode=1, prob_a=prob_b=0 -> count=256, saturated=1, done 257 cycles after start.
